// File: rtl/keypad_time_entry_if.sv
// Keypad time-entry bus: scanner/timekeeper inputs and editor outputs.
interface keypad_time_entry_if;
   logic        key_flag;
   logic [3:0]  key_value;
   logic [23:0] cur_bcd;
   logic        edit_mode;
   logic [2:0]  cursor;
   logic [23:0] entry_bcd;
   logic        load;
   logic        err;

   // Driver side (scanner, timekeeper, or a bench).
   modport master (
      output key_flag, key_value, cur_bcd,
      input  edit_mode, cursor, entry_bcd, load, err
   );

   // Editor side.
   modport slave (
      input  key_flag, key_value, cur_bcd,
      output edit_mode, cursor, entry_bcd, load, err
   );
endinterface

// File: rtl/keypad_time_entry.sv
// Debounces held keypad codes into single key events and runs an HH:MM:SS
// six-digit BCD entry editor with load/err strobes.
module keypad_time_entry #(
   parameter int unsigned DEBOUNCE = 4
) (
   input logic               clk,
   input logic               reset,
   keypad_time_entry_if.slave kp
);

   localparam logic [7:0] DebTarget = 8'(DEBOUNCE);
   localparam logic [3:0] KeySet    = 4'd10;
   localparam logic [3:0] KeyBack   = 4'd11;
   localparam logic [3:0] KeyEnter  = 4'd12;
   localparam logic [3:0] KeyCancel = 4'd13;
   localparam logic [2:0] CursorEnd = 3'd6;

   typedef enum logic [0:0] {StIdle, StEdit} state_e;

   state_e      state_q, state_d;
   logic [7:0]  deb_cnt_q, deb_cnt_d;
   logic        armed_q, armed_d;
   logic        accept;
   logic [2:0]  cursor_q, cursor_d;
   logic [23:0] entry_q, entry_d;
   logic        load_q, load_d;
   logic        err_q, err_d;
   logic        is_digit;
   logic [3:0]  digit_max;

   assign is_digit = (kp.key_value <= 4'd9);

   // Debounce counter; a press is accepted once, on the edge it reaches the target.
   always_comb begin
      deb_cnt_d = deb_cnt_q;
      armed_d   = armed_q;
      accept    = 1'b0;
      if (!kp.key_flag) begin
         deb_cnt_d = '0;
         armed_d   = 1'b1;
      end else if (deb_cnt_q != DebTarget) begin
         deb_cnt_d = deb_cnt_q + 8'd1;
         if ((deb_cnt_d == DebTarget) && armed_q) begin
            accept  = 1'b1;
            armed_d = 1'b0;
         end
      end
   end

   // Largest legal digit at the cursor; Hu depends on the Ht already in the buffer.
   always_comb begin
      digit_max = 4'd9;
      case (cursor_q)
         3'd0:       digit_max = 4'd2;
         3'd1:       digit_max = (entry_q[23:20] == 4'd2) ? 4'd3 : 4'd9;
         3'd2, 3'd4: digit_max = 4'd5;
         default:    digit_max = 4'd9;
      endcase
   end

   // State register and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         deb_cnt_q <= '0;
         armed_q   <= 1'b1;
         cursor_q  <= '0;
         entry_q   <= '0;
         load_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         deb_cnt_q <= deb_cnt_d;
         armed_q   <= armed_d;
         cursor_q  <= cursor_d;
         entry_q   <= entry_d;
         load_q    <= load_d;
         err_q     <= err_d;
      end
   end

   // Next-state: SET enters EDIT; a completed ENTER or CANCEL leaves it.
   always_comb begin
      state_d = state_q;
      if (accept) begin
         unique case (state_q)
            StIdle: if (kp.key_value == KeySet) state_d = StEdit;
            StEdit: begin
               if (kp.key_value == KeyCancel) state_d = StIdle;
               if ((kp.key_value == KeyEnter) && (cursor_q == CursorEnd)) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Edit buffer, cursor and strobe next values for the accepted key.
   always_comb begin
      cursor_d = cursor_q;
      entry_d  = entry_q;
      load_d   = 1'b0;
      err_d    = 1'b0;
      if (accept) begin
         unique case (state_q)
            StIdle: begin
               if (kp.key_value == KeySet) begin
                  entry_d  = kp.cur_bcd;
                  cursor_d = '0;
               end
            end
            StEdit: begin
               if (is_digit) begin
                  if ((cursor_q == CursorEnd) || (kp.key_value > digit_max)) begin
                     err_d = 1'b1;
                  end else begin
                     for (int i = 0; i < 6; i++) begin
                        if (cursor_q == 3'(i)) entry_d[23-4*i -: 4] = kp.key_value;
                     end
                     cursor_d = cursor_q + 3'd1;
                  end
               end else begin
                  case (kp.key_value)
                     KeySet: begin
                        entry_d  = kp.cur_bcd;
                        cursor_d = '0;
                     end
                     KeyBack: begin
                        if (cursor_q != 3'd0) cursor_d = cursor_q - 3'd1;
                        else                  err_d    = 1'b1;
                     end
                     KeyEnter: begin
                        if (cursor_q == CursorEnd) load_d = 1'b1;
                        else                       err_d  = 1'b1;
                     end
                     default: ;  // CANCEL handled by next-state; 14/15 ignored
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs straight from registers.
   always_comb begin
      kp.edit_mode = (state_q == StEdit);
      kp.cursor    = cursor_q;
      kp.entry_bcd = entry_q;
      kp.load      = load_q;
      kp.err       = err_q;
   end

endmodule

// File: tb/tb_keypad_time_entry.sv
// Bench for keypad_time_entry: directed table, corner sequences, random run
// against a digit-array reference model.
module tb_keypad_time_entry;

   localparam int DEB = 4;
   localparam logic [3:0] K_SET = 4'd10, K_BACK = 4'd11, K_ENTER = 4'd12, K_CANCEL = 4'd13;

   typedef struct {
      logic [3:0]  key;
      logic [23:0] cur;
      bit          edit;
      int          cursor;
      logic [23:0] entry;
      int          loads;
      int          errs;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   keypad_time_entry_if kp ();
   keypad_time_entry #(.DEBOUNCE(DEB)) dut (.clk(clk), .reset(reset), .kp(kp));

   int n_vec  = 0;
   int n_fail = 0;
   int cnt_load, cnt_err;

   // Reference model state: digits as plain integers.
   int m_run;
   bit m_edit;
   int m_cursor;
   int m_dig[6];
   bit m_load, m_err;

   function automatic logic [23:0] m_entry();
      logic [23:0] e;
      for (int i = 0; i < 6; i++) e[23-4*i -: 4] = 4'(m_dig[i]);
      return e;
   endfunction

   function automatic int m_limit(int pos);
      if (pos == 0) return 2;
      if (pos == 1) return (m_dig[0] == 2) ? 3 : 9;
      if (pos == 2 || pos == 4) return 5;
      return 9;
   endfunction

   task automatic m_reload();
      for (int i = 0; i < 6; i++) m_dig[i] = int'(kp.cur_bcd[23-4*i -: 4]);
      m_cursor = 0;
   endtask

   task automatic m_key(input int k);
      if (!m_edit) begin
         if (k == 10) begin
            m_reload();
            m_edit = 1'b1;
         end
      end else if (k <= 9) begin
         if (m_cursor == 6 || k > m_limit(m_cursor)) m_err = 1'b1;
         else begin
            m_dig[m_cursor] = k;
            m_cursor++;
         end
      end else if (k == 10) begin
         m_reload();
      end else if (k == 11) begin
         if (m_cursor > 0) m_cursor--;
         else m_err = 1'b1;
      end else if (k == 12) begin
         if (m_cursor == 6) begin
            m_load = 1'b1;
            m_edit = 1'b0;
         end else m_err = 1'b1;
      end else if (k == 13) begin
         m_edit = 1'b0;
      end
   endtask

   task automatic m_step();
      m_load = 1'b0;
      m_err  = 1'b0;
      if (reset) begin
         m_run = 0; m_edit = 1'b0; m_cursor = 0;
         for (int i = 0; i < 6; i++) m_dig[i] = 0;
      end else if (!kp.key_flag) begin
         m_run = 0;
      end else begin
         m_run++;
         if (m_run == DEB) m_key(int'(kp.key_value));
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // One clock: advance the model on the edge, then compare all outputs.
   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
      if (kp.load) cnt_load++;
      if (kp.err)  cnt_err++;
      n_vec++;
      if (kp.edit_mode !== m_edit || int'(kp.cursor) != m_cursor || kp.entry_bcd !== m_entry()
          || kp.load !== m_load || kp.err !== m_err) begin
         n_fail++;
         $display("FAIL cycle t=%0t: dut edit=%0b cur=%0d entry=%h load=%0b err=%0b, model edit=%0b cur=%0d entry=%h load=%0b err=%0b",
                  $time, kp.edit_mode, kp.cursor, kp.entry_bcd, kp.load, kp.err,
                  m_edit, m_cursor, m_entry(), m_load, m_err);
      end
   endtask

   task automatic press(input logic [3:0] k, input int hold, input int gap);
      kp.key_value = k;
      kp.key_flag  = 1'b1;
      repeat (hold) tick();
      kp.key_flag  = 1'b0;
      kp.key_value = 4'($urandom);
      repeat (gap) tick();
   endtask

   vec_t tbl[$];

   initial begin
      tbl.push_back('{K_SET,    24'h123456, 1'b1, 0, 24'h123456, 0, 0});
      tbl.push_back('{4'd2,     24'h999999, 1'b1, 1, 24'h223456, 0, 0});
      tbl.push_back('{4'd3,     24'h000000, 1'b1, 2, 24'h233456, 0, 0});
      tbl.push_back('{4'd5,     24'h000000, 1'b1, 3, 24'h235456, 0, 0});
      tbl.push_back('{4'd9,     24'h000000, 1'b1, 4, 24'h235956, 0, 0});
      tbl.push_back('{4'd0,     24'h000000, 1'b1, 5, 24'h235906, 0, 0});
      tbl.push_back('{4'd7,     24'h000000, 1'b1, 6, 24'h235907, 0, 0});
      tbl.push_back('{K_ENTER,  24'h000000, 1'b0, 6, 24'h235907, 1, 0});
      tbl.push_back('{K_SET,    24'h123456, 1'b1, 0, 24'h123456, 0, 0});
      tbl.push_back('{4'd2,     24'h123456, 1'b1, 1, 24'h223456, 0, 0});
      tbl.push_back('{4'd4,     24'h123456, 1'b1, 1, 24'h223456, 0, 1});
      tbl.push_back('{4'd3,     24'h123456, 1'b1, 2, 24'h233456, 0, 0});
      tbl.push_back('{4'd6,     24'h123456, 1'b1, 2, 24'h233456, 0, 1});
      tbl.push_back('{K_CANCEL, 24'h123456, 1'b0, 2, 24'h233456, 0, 0});
      tbl.push_back('{K_SET,    24'h000000, 1'b1, 0, 24'h000000, 0, 0});
      tbl.push_back('{4'd1,     24'h000000, 1'b1, 1, 24'h100000, 0, 0});
      tbl.push_back('{4'd2,     24'h000000, 1'b1, 2, 24'h120000, 0, 0});
      tbl.push_back('{K_BACK,   24'h000000, 1'b1, 1, 24'h120000, 0, 0});
      tbl.push_back('{K_BACK,   24'h000000, 1'b1, 0, 24'h120000, 0, 0});
      tbl.push_back('{K_BACK,   24'h000000, 1'b1, 0, 24'h120000, 0, 1});
      tbl.push_back('{K_ENTER,  24'h000000, 1'b1, 0, 24'h120000, 0, 1});
      tbl.push_back('{K_CANCEL, 24'h000000, 1'b0, 0, 24'h120000, 0, 0});
      tbl.push_back('{4'd14,    24'h000000, 1'b0, 0, 24'h120000, 0, 0});
      tbl.push_back('{4'd5,     24'h000000, 1'b0, 0, 24'h120000, 0, 0});
      tbl.push_back('{K_BACK,   24'h000000, 1'b0, 0, 24'h120000, 0, 0});
      tbl.push_back('{K_SET,    24'h235959, 1'b1, 0, 24'h235959, 0, 0});
      tbl.push_back('{4'd2,     24'h000000, 1'b1, 1, 24'h235959, 0, 0});
      tbl.push_back('{4'd3,     24'h000000, 1'b1, 2, 24'h235959, 0, 0});
      tbl.push_back('{4'd15,    24'h000000, 1'b1, 2, 24'h235959, 0, 0});
      tbl.push_back('{K_SET,    24'h010203, 1'b1, 0, 24'h010203, 0, 0});
      tbl.push_back('{4'd3,     24'h010203, 1'b1, 0, 24'h010203, 0, 1});
      tbl.push_back('{4'd1,     24'h010203, 1'b1, 1, 24'h110203, 0, 0});
      tbl.push_back('{4'd9,     24'h010203, 1'b1, 2, 24'h190203, 0, 0});
      tbl.push_back('{4'd5,     24'h010203, 1'b1, 3, 24'h195203, 0, 0});
      tbl.push_back('{4'd9,     24'h010203, 1'b1, 4, 24'h195903, 0, 0});
      tbl.push_back('{4'd6,     24'h010203, 1'b1, 4, 24'h195903, 0, 1});
      tbl.push_back('{4'd5,     24'h010203, 1'b1, 5, 24'h195953, 0, 0});
      tbl.push_back('{4'd9,     24'h010203, 1'b1, 6, 24'h195959, 0, 0});
      tbl.push_back('{4'd1,     24'h010203, 1'b1, 6, 24'h195959, 0, 1});
      tbl.push_back('{K_ENTER,  24'h010203, 1'b0, 6, 24'h195959, 1, 0});

      reset        = 1'b1;
      kp.key_flag  = 1'b0;
      kp.key_value = 4'd0;
      kp.cur_bcd   = 24'h123456;
      cnt_load = 0; cnt_err = 0;
      tick();
      tick();
      check("rst_edit",   int'(kp.edit_mode), 0);
      check("rst_cursor", int'(kp.cursor), 0);
      check("rst_entry",  int'(kp.entry_bcd), 0);
      check("rst_strobe", int'({kp.load, kp.err}), 0);
      reset = 1'b0;
      tick();

      // Accept latency: edit_mode appears exactly DEB edges after key_flag rises.
      kp.key_value = K_SET;
      kp.key_flag  = 1'b1;
      repeat (DEB - 1) tick();
      check("lat_before", int'(kp.edit_mode), 0);
      tick();
      check("lat_edit",  int'(kp.edit_mode), 1);
      check("lat_entry", int'(kp.entry_bcd), 32'h123456);
      repeat (6) tick();
      kp.key_flag = 1'b0;
      repeat (2) tick();
      press(K_CANCEL, 10, 2);
      check("cancel_idle", int'(kp.edit_mode), 0);

      foreach (tbl[i]) begin
         kp.cur_bcd = tbl[i].cur;
         cnt_load = 0; cnt_err = 0;
         press(tbl[i].key, 10, 2);
         check($sformatf("tbl%0d_edit", i),   int'(kp.edit_mode), int'(tbl[i].edit));
         check($sformatf("tbl%0d_cursor", i), int'(kp.cursor), tbl[i].cursor);
         check($sformatf("tbl%0d_entry", i),  int'(kp.entry_bcd), int'(tbl[i].entry));
         check($sformatf("tbl%0d_loads", i),  cnt_load, tbl[i].loads);
         check($sformatf("tbl%0d_errs", i),   cnt_err, tbl[i].errs);
      end

      // Short glitches below the debounce count produce nothing.
      kp.cur_bcd = 24'h000000;
      press(K_SET, 10, 2);
      cnt_load = 0; cnt_err = 0;
      press(4'd1, DEB - 1, 1);
      press(4'd1, DEB - 1, 2);
      check("glitch_cursor", int'(kp.cursor), 0);
      check("glitch_entry",  int'(kp.entry_bcd), 0);
      // Long hold yields exactly one write.
      press(4'd1, 100, 2);
      check("hold_cursor", int'(kp.cursor), 1);
      check("hold_entry",  int'(kp.entry_bcd), 32'h100000);
      check("hold_errs",   cnt_err, 0);

      // Reset mid-edit at cursor 4 aborts with no strobe.
      press(4'd2, 10, 2);
      press(4'd3, 10, 2);
      press(4'd4, 10, 2);
      check("pre_rst_cursor", int'(kp.cursor), 4);
      reset = 1'b1;
      tick();
      check("midrst_edit",   int'(kp.edit_mode), 0);
      check("midrst_cursor", int'(kp.cursor), 0);
      check("midrst_entry",  int'(kp.entry_bcd), 0);
      check("midrst_strobe", int'({kp.load, kp.err}), 0);
      reset = 1'b0;
      tick();

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [3:0] k;
         if (!m_edit && $urandom_range(0, 1) == 0) k = K_SET;
         else if ($urandom_range(0, 99) < 60) k = 4'($urandom_range(0, 9));
         else k = 4'($urandom_range(10, 15));
         if ($urandom_range(0, 9) == 0) kp.cur_bcd = 24'($urandom);
         if ($urandom_range(0, 49) == 0) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end
         press(k, $urandom_range(1, 8), $urandom_range(0, 4));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
